spi_master_gen: RTL

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_master_gen_pkg.sv | 19 +
 rtl/spi_clkgen.sv | 44 ++++
 rtl/spi_master_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spi_master_gen_pkg.sv
// rtl/spi_master_gen_pkg.sv - shared FSM encoding, defaults and helpers for the SPI master
package spi_master_gen_pkg;

  localparam int DW_DEF  = 32;
  localparam int NCS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // Keeps cs_sel at least one bit wide when only one slave exists.
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCK half-period down-counter producing leading/trailing edge strobes
module spi_clkgen
  import spi_master_gen_pkg::*;
(
  input  logic       clk,
  input  logic       resetb,
  input  logic       start,
  input  logic       en,
  input  logic       xfer,
  input  logic [7:0] start_div,
  input  logic [7:0] div,
  output logic       tick,
  output logic       lead_edge,
  output logic       trail_edge
);

  logic [8:0] cnt;
  logic       phase;

  assign tick       = en && (cnt == 9'd0);
  assign lead_edge  = tick && xfer && !phase;
  assign trail_edge = tick && xfer && phase;

  // The first half-period is loaded one longer to absorb the capture cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (start) begin
        cnt <= {1'b0, start_div} + 9'd1;
      end else if (en) begin
        cnt <= (cnt == 9'd0) ? {1'b0, div} : cnt - 9'd1;
      end

      if (!xfer) begin
        phase <= 1'b0;
      end else if (tick) begin
        phase <= ~phase;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - configurable SPI master: FSM, shift logic and chip-select control
module spi_master_gen
  import spi_master_gen_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCS = NCS_DEF
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     wr,
  input  logic [DW-1:0]            din,
  input  logic [7:0]               divider,
  input  logic [5:0]               bits,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic                     lsb_first,
  input  logic [cs_width(NCS)-1:0] cs_sel,
  input  logic                     miso,
  output logic                     sck,
  output logic                     mosi,
  output logic [NCS-1:0]           cs_n,
  output logic                     busy,
  output logic                     done,
  output logic [DW-1:0]            dout
);

  state_t state, state_nxt;

  logic [DW-1:0]            din_q;
  logic [7:0]               div_q;
  logic [5:0]               n_q;
  logic                     cpol_q, cpha_q, lsb_q;
  logic [cs_width(NCS)-1:0] cs_q;
  logic [6:0]               ecnt;

  logic       start, en, xfer;
  logic       tick, lead_edge, trail_edge;
  logic [5:0] n_in, idx, nb;
  logic       sck_edge, last_edge, sample, shift;
  logic [NCS-1:0] cs_mask;

  function automatic logic bit_of(input logic [DW-1:0] w, input logic [5:0] b,
                                  input logic [5:0] n, input logic lsb);
    logic [DW-1:0] s;
    s = lsb ? (w >> b) : (w >> (n - 6'd1 - b));
    return s[0];
  endfunction

  spi_clkgen u_clkgen (
    .clk        (clk),
    .resetb     (resetb),
    .start      (start),
    .en         (en),
    .xfer       (xfer),
    .start_div  (divider),
    .div        (div_q),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  assign n_in      = (bits == 6'd0 || int'(bits) > DW) ? 6'(DW) : bits;
  assign idx       = ecnt[6:1];
  assign sck_edge  = lead_edge || trail_edge;
  assign last_edge = (ecnt == ({n_q, 1'b0} - 7'd1));
  assign sample    = cpha_q ? trail_edge : lead_edge;
  // Mode 0/2 pre-presents each bit on the previous trailing edge; the last one has no successor.
  assign shift     = cpha_q ? lead_edge : (trail_edge && (idx + 6'd1 != n_q));
  assign nb        = cpha_q ? idx : idx + 6'd1;
  assign cs_mask   = ~(NCS'(1) << cs_q);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = XFER;
      XFER:    if (trail_edge && last_edge) state_nxt = TRAIL;
      TRAIL:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    cs_n  = '1;
    start = 1'b0;
    en    = 1'b0;
    xfer  = 1'b0;
    case (state)
      IDLE:  start = wr;
      LEAD:  begin busy = 1'b1; cs_n = cs_mask; en = 1'b1; end
      XFER:  begin busy = 1'b1; cs_n = cs_mask; en = 1'b1; xfer = 1'b1; end
      TRAIL: begin busy = 1'b1; cs_n = cs_mask; en = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      din_q  <= '0;
      div_q  <= '0;
      n_q    <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      cs_q   <= '0;
      ecnt   <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
      dout   <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == TRAIL) && tick;
      if (start) begin
        din_q  <= din;
        div_q  <= divider;
        n_q    <= n_in;
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        cs_q   <= cs_sel;
        ecnt   <= '0;
        sck    <= cpol;
        mosi   <= bit_of(din, 6'd0, n_in, lsb_first);
      end else begin
        if (sck_edge) begin
          sck  <= ~sck;
          ecnt <= ecnt + 7'd1;
        end
        // dout keeps the previous result until the first new sample overwrites it.
        if (sample) begin
          if (idx == 6'd0) begin
            dout <= DW'(miso);
          end else if (lsb_q) begin
            dout <= dout | (DW'(miso) << idx);
          end else begin
            dout <= {dout[DW-2:0], miso};
          end
        end
        if (shift) begin
          mosi <= bit_of(din_q, nb, n_q, lsb_q);
        end
      end
    end
  end

  logic unused_cpol;
  assign unused_cpol = cpol_q;

endmodule
